cv32e40x_rvfi_instr_tracker: RTL and testbench

CV32E40X_RVFI_INSTR_TRACKER -- requirements
Module: cv32e40x_rvfi_instr_tracker

---
 rtl/cv32e40x_pkg.sv | 11 +
 rtl/cv32e40x_rvfi_pkg.sv | 22 ++
 rtl/cv32e40x_rvfi_instr_ptrs.sv | 101 ++++++++++
 rtl/cv32e40x_rvfi_instr_tracker.sv | 142 ++++++++++++++
 tb/tb_cv32e40x_rvfi_instr_tracker.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40x_pkg.sv
// Core-wide types shared between the CV32E40X pipeline and its trace helpers.
package cv32e40x_pkg;

    // Outcome of the MPU check attached to an instruction-side OBI response.
    typedef enum logic [1:0] {
        MPU_OK       = 2'h0,
        MPU_RE_FAULT = 2'h1,
        MPU_WR_FAULT = 2'h2
    } mpu_status_e;

endpackage

// File: rtl/cv32e40x_rvfi_pkg.sv
// Types used by the RVFI instruction tracker to present IF-aligned fetch data.
package cv32e40x_rvfi_pkg;

    import cv32e40x_pkg::*;

    // One instruction as seen by IF: the address phase that fetched its first
    // halfword plus the (possibly two-word) response it was assembled from.
    typedef struct packed {
        logic [31:0] req_payload;
        logic [31:0] rdata;
        logic        err;
        mpu_status_e mpu_status;
    } rvfi_obi_instr_t;

    // Protocol errors the tracker can flag.
    typedef enum logic [1:0] {
        TRK_ERR_NONE      = 2'h0,
        TRK_ERR_OVERFLOW  = 2'h1,
        TRK_ERR_UNDERFLOW = 2'h2
    } rvfi_trk_err_e;

endpackage

// File: rtl/cv32e40x_rvfi_instr_ptrs.sv
// Pointer and counter bookkeeping for the RVFI instruction tracker FIFO.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module cv32e40x_rvfi_instr_ptrs #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   accept_i,
    input  logic                   resp_valid_i,
    input  logic                   pop_i,
    input  logic                   kill_i,
    output logic [$clog2(DEPTH):0] rptr_o,
    output logic [$clog2(DEPTH):0] wptr_req_o,
    output logic [$clog2(DEPTH):0] wptr_resp_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [$clog2(DEPTH):0] outstanding_o,
    output logic                   push_o,
    output logic                   resp_o,
    output logic                   overflow_o,
    output logic                   underflow_o
);

    localparam int          PW         = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE    = (PW + 1)'(1);
    localparam logic [PW:0] FULL_LEVEL = (PW + 1)'(DEPTH);
    localparam logic [PW:0] MAX_OUT    = (PW + 1)'(MAX_OUTSTANDING);

    logic [PW:0] rptr_q, rptr_d;
    logic [PW:0] wptr_req_q, wptr_req_d;
    logic [PW:0] wptr_resp_q, wptr_resp_d;
    logic [PW:0] outst_q, outst_d;
    logic [PW:0] level;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic        ovf_evt, unf_evt, push, resp_ok, pop_ok;

    // Next-state for pointers, in-flight count and sticky error flags
    always_comb begin
        level       = wptr_req_q - rptr_q;
        // A rejected push leaves every pointer and counter untouched
        ovf_evt     = accept_i & (((level == FULL_LEVEL) & ~pop_i) |
                                  ((outst_q == MAX_OUT) & ~resp_valid_i));
        push        = accept_i & ~ovf_evt;
        resp_ok     = resp_valid_i & (outst_q != '0);
        pop_ok      = pop_i & (level != '0);
        unf_evt     = (resp_valid_i & (outst_q == '0)) | (pop_i & (level == '0));

        wptr_req_d  = push    ? wptr_req_q + PTR_ONE  : wptr_req_q;
        wptr_resp_d = resp_ok ? wptr_resp_q + PTR_ONE : wptr_resp_q;

        outst_d = outst_q;
        if (push && !resp_ok) begin
            outst_d = outst_q + PTR_ONE;
        end else if (!push && resp_ok) begin
            outst_d = outst_q - PTR_ONE;
        end

        // Kill skips every slot still owed a response; a same-cycle accept
        // lands at the old wptr_req and so becomes the next readable entry.
        rptr_d = rptr_q;
        if (kill_i) begin
            rptr_d = wptr_resp_q + outst_q;
        end else if (pop_ok) begin
            rptr_d = rptr_q + PTR_ONE;
        end

        overflow_d  = overflow_q | ovf_evt;
        underflow_d = underflow_q | unf_evt;
    end

    // State registers; reset wins over kill, push and pop
    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q      <= '0;
            wptr_req_q  <= '0;
            wptr_resp_q <= '0;
            outst_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rptr_q      <= rptr_d;
            wptr_req_q  <= wptr_req_d;
            wptr_resp_q <= wptr_resp_d;
            outst_q     <= outst_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign rptr_o        = rptr_q;
    assign wptr_req_o    = wptr_req_q;
    assign wptr_resp_o   = wptr_resp_q;
    assign level_o       = level;
    assign outstanding_o = outst_q;
    assign push_o        = push;
    assign resp_o        = resp_ok;
    assign overflow_o    = overflow_q;
    assign underflow_o   = underflow_q;

endmodule

// File: rtl/cv32e40x_rvfi_instr_tracker.sv
// Tracks instruction-side OBI transactions and re-presents them aligned to
// what IF actually consumes (compressed pairs, misaligned 32-bit instructions).
module cv32e40x_rvfi_instr_tracker
    import cv32e40x_pkg::*;
    import cv32e40x_rvfi_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trans_valid_i,
    input  logic                   trans_ready_i,
    input  logic [31:0]            req_addr_i,
    input  logic                   resp_valid_i,
    input  logic [31:0]            resp_rdata_i,
    input  logic                   resp_err_i,
    input  mpu_status_e            mpu_status_i,
    input  logic                   prefetch_valid_i,
    input  logic                   prefetch_ready_i,
    input  logic [31:0]            prefetch_addr_i,
    input  logic                   prefetch_compressed_i,
    input  logic                   kill_if_i,
    output rvfi_obi_instr_t        instr_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic [$clog2(DEPTH):0] outstanding_o,
    output logic                   overflow_o,
    output logic                   underflow_o
);

    localparam int PW = $clog2(DEPTH);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gen_bad_depth
        $error("cv32e40x_rvfi_instr_tracker: DEPTH must be a power of 2 and >= 4");
    end
    if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > DEPTH - 1)) begin : gen_bad_max_out
        $error("cv32e40x_rvfi_instr_tracker: MAX_OUTSTANDING must be in 1..DEPTH-1");
    end

    logic [PW:0]  rptr, rptr_nxt, wptr_req, wptr_resp;
    logic         accept, pop, push, resp_ok;
    logic         unused_addr;

    logic [31:0]  addr_q  [DEPTH];
    logic [31:0]  rdata_q [DEPTH];
    logic         err_q   [DEPTH];
    mpu_status_e  mpu_q   [DEPTH];

    logic [31:0]  cur_rdata, nxt_rdata;
    logic         cur_err, nxt_err;
    mpu_status_e  cur_mpu, nxt_mpu;

    assign accept      = trans_valid_i & trans_ready_i;
    // A compressed instruction in the low half leaves the word for its partner
    assign pop         = prefetch_valid_i & prefetch_ready_i &
                         (~prefetch_compressed_i | (prefetch_addr_i[1:0] == 2'b10));
    assign rptr_nxt    = rptr + (PW + 1)'(1);
    assign unused_addr = ^prefetch_addr_i[31:2];

    cv32e40x_rvfi_instr_ptrs #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_ptrs (
        .clk           (clk),
        .rst           (rst),
        .accept_i      (accept),
        .resp_valid_i  (resp_valid_i),
        .pop_i         (pop),
        .kill_i        (kill_if_i),
        .rptr_o        (rptr),
        .wptr_req_o    (wptr_req),
        .wptr_resp_o   (wptr_resp),
        .level_o       (level_o),
        .outstanding_o (outstanding_o),
        .push_o        (push),
        .resp_o        (resp_ok),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    // Entry storage: address phase and response phase fill different slots
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                rdata_q[i] <= '0;
                err_q[i]   <= 1'b0;
                mpu_q[i]   <= MPU_OK;
            end
        end else begin
            if (push) begin
                addr_q[wptr_req[PW-1:0]] <= req_addr_i;
            end
            if (resp_ok) begin
                rdata_q[wptr_resp[PW-1:0]] <= resp_rdata_i;
                err_q[wptr_resp[PW-1:0]]   <= resp_err_i;
                mpu_q[wptr_resp[PW-1:0]]   <= mpu_status_i;
            end
        end
    end

    // Assemble the IF-aligned packet from the current and following word
    always_comb begin
        // Full-pointer compare: a completely filled FIFO whose responses have
        // all arrived shares rptr's index with wptr_resp but must not bypass.
        cur_rdata = rdata_q[rptr[PW-1:0]];
        cur_err   = err_q[rptr[PW-1:0]];
        cur_mpu   = mpu_q[rptr[PW-1:0]];
        if (rptr == wptr_resp) begin
            cur_rdata = resp_rdata_i;
            cur_err   = resp_err_i;
            cur_mpu   = mpu_status_i;
        end

        nxt_rdata = rdata_q[rptr_nxt[PW-1:0]];
        nxt_err   = err_q[rptr_nxt[PW-1:0]];
        nxt_mpu   = mpu_q[rptr_nxt[PW-1:0]];
        if (rptr_nxt == wptr_resp) begin
            nxt_rdata = resp_rdata_i;
            nxt_err   = resp_err_i;
            nxt_mpu   = mpu_status_i;
        end

        instr_o             = '0;
        instr_o.req_payload = addr_q[rptr[PW-1:0]];
        if (prefetch_compressed_i) begin
            instr_o.rdata      = prefetch_addr_i[1] ? {16'h0, cur_rdata[31:16]}
                                                    : {16'h0, cur_rdata[15:0]};
            instr_o.err        = cur_err;
            instr_o.mpu_status = cur_mpu;
        end else if (!prefetch_addr_i[1]) begin
            instr_o.rdata      = cur_rdata;
            instr_o.err        = cur_err;
            instr_o.mpu_status = cur_mpu;
        end else begin
            instr_o.rdata      = {nxt_rdata[15:0], cur_rdata[31:16]};
            instr_o.err        = cur_err | nxt_err;
            instr_o.mpu_status = (nxt_mpu != MPU_OK) ? MPU_RE_FAULT : cur_mpu;
        end
    end

endmodule

// File: tb/tb_cv32e40x_rvfi_instr_tracker.sv
// Bench for the RVFI instruction tracker: directed scenarios then random
// traffic, all compared against a sequence-number model of the FIFO.
module tb_cv32e40x_rvfi_instr_tracker;
    import cv32e40x_pkg::*;
    import cv32e40x_rvfi_pkg::*;

    localparam int DEPTH = 8;
    localparam int MAXO  = 2;
    localparam int MW    = 4096;

    logic            clk = 1'b0;
    logic            rst;
    logic            trans_valid_i, trans_ready_i;
    logic [31:0]     req_addr_i;
    logic            resp_valid_i;
    logic [31:0]     resp_rdata_i;
    logic            resp_err_i;
    mpu_status_e     mpu_status_i;
    logic            prefetch_valid_i, prefetch_ready_i;
    logic [31:0]     prefetch_addr_i;
    logic            prefetch_compressed_i;
    logic            kill_if_i;
    rvfi_obi_instr_t instr_o;
    logic [3:0]      level_o, outstanding_o;
    logic            overflow_o, underflow_o;

    always #5 clk = ~clk;

    cv32e40x_rvfi_instr_tracker #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .trans_valid_i         (trans_valid_i),
        .trans_ready_i         (trans_ready_i),
        .req_addr_i            (req_addr_i),
        .resp_valid_i          (resp_valid_i),
        .resp_rdata_i          (resp_rdata_i),
        .resp_err_i            (resp_err_i),
        .mpu_status_i          (mpu_status_i),
        .prefetch_valid_i      (prefetch_valid_i),
        .prefetch_ready_i      (prefetch_ready_i),
        .prefetch_addr_i       (prefetch_addr_i),
        .prefetch_compressed_i (prefetch_compressed_i),
        .kill_if_i             (kill_if_i),
        .instr_o               (instr_o),
        .level_o               (level_o),
        .outstanding_o         (outstanding_o),
        .overflow_o            (overflow_o),
        .underflow_o           (underflow_o)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: absolute sequence numbers for reads, requests and responses
    int          m_rd, m_wq, m_wr, m_outst;
    logic        m_ovf, m_unf;
    logic [31:0] m_addr  [MW];
    logic [31:0] m_rdata [MW];
    logic        m_err   [MW];
    mpu_status_e m_mpu   [MW];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int ix(input int a);
        return a & (MW - 1);
    endfunction

    function automatic logic in_pop();
        return prefetch_valid_i & prefetch_ready_i &
               (!prefetch_compressed_i || prefetch_addr_i[1:0] == 2'b10);
    endfunction

    // Response word for sequence number n: arrived, arriving now, or unknown
    task automatic get_word(input int n, output logic ok, output logic [31:0] w,
                            output logic e, output mpu_status_e m);
        ok = 1'b1; w = resp_rdata_i; e = resp_err_i; m = mpu_status_i;
        if (n < m_wr) begin
            w = m_rdata[ix(n)]; e = m_err[ix(n)]; m = m_mpu[ix(n)];
        end else if (n > m_wr) begin
            ok = 1'b0;
        end
    endtask

    task automatic model_check();
        int lvl;
        logic ck, nk, ce, ne, ee;
        logic [31:0] cw, nw, ew;
        mpu_status_e cm, nm, em;
        lvl = m_wq - m_rd;
        check("level", 32'(level_o), 32'(lvl));
        check("outstanding", 32'(outstanding_o), 32'(m_outst));
        check("overflow", 32'(overflow_o), 32'(m_ovf));
        check("underflow", 32'(underflow_o), 32'(m_unf));
        if (lvl >= 1) begin
            check("req_payload", instr_o.req_payload, m_addr[ix(m_rd)]);
            get_word(m_rd, ck, cw, ce, cm);
            get_word(m_rd + 1, nk, nw, ne, nm);
            if (ck && (prefetch_compressed_i || !prefetch_addr_i[1])) begin
                ew = prefetch_compressed_i ? (prefetch_addr_i[1] ? {16'h0, cw[31:16]} : {16'h0, cw[15:0]}) : cw;
                check("rdata", instr_o.rdata, ew);
                check("err", 32'(instr_o.err), 32'(ce));
                check("mpu", 32'(instr_o.mpu_status), 32'(cm));
            end else if (ck && nk && lvl >= 2) begin
                ew = {nw[15:0], cw[31:16]};
                ee = ce | ne;
                em = (nm != MPU_OK) ? MPU_RE_FAULT : cm;
                check("rdata_mis", instr_o.rdata, ew);
                check("err_mis", 32'(instr_o.err), 32'(ee));
                check("mpu_mis", 32'(instr_o.mpu_status), 32'(em));
            end
        end
    endtask

    task automatic model_edge();
        int lvl;
        logic p, ovf_e, push, rok;
        if (rst) begin
            m_rd = 0; m_wq = 0; m_wr = 0; m_outst = 0; m_ovf = 1'b0; m_unf = 1'b0;
            return;
        end
        lvl   = m_wq - m_rd;
        p     = in_pop();
        ovf_e = trans_valid_i && trans_ready_i &&
                ((lvl == DEPTH && !p) || (m_outst == MAXO && !resp_valid_i));
        push  = trans_valid_i && trans_ready_i && !ovf_e;
        rok   = resp_valid_i && m_outst != 0;
        if (ovf_e) m_ovf = 1'b1;
        if ((resp_valid_i && m_outst == 0) || (p && lvl == 0)) m_unf = 1'b1;
        if (kill_if_i) m_rd = m_wr + m_outst;
        else if (p && lvl != 0) m_rd++;
        if (push) begin
            m_addr[ix(m_wq)] = req_addr_i;
            m_wq++;
        end
        if (rok) begin
            m_rdata[ix(m_wr)] = resp_rdata_i;
            m_err[ix(m_wr)]   = resp_err_i;
            m_mpu[ix(m_wr)]   = mpu_status_i;
            m_wr++;
        end
        m_outst = m_outst + int'(push) - int'(rok);
    endtask

    task automatic idle();
        trans_valid_i = 0; trans_ready_i = 0; req_addr_i = '0;
        resp_valid_i = 0; resp_rdata_i = '0; resp_err_i = 0; mpu_status_i = MPU_OK;
        prefetch_valid_i = 0; prefetch_ready_i = 0; prefetch_addr_i = '0;
        prefetch_compressed_i = 0; kill_if_i = 0;
    endtask

    task automatic cyc();
        #4;
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        model_edge();
        #1;
        idle();
    endtask

    task automatic acc_req(input logic [31:0] a);
        trans_valid_i = 1; trans_ready_i = 1; req_addr_i = a;
    endtask

    task automatic resp(input logic [31:0] d, input logic e, input mpu_status_e m);
        resp_valid_i = 1; resp_rdata_i = d; resp_err_i = e; mpu_status_i = m;
    endtask

    task automatic fetch(input logic [31:0] a, input logic c);
        prefetch_valid_i = 1; prefetch_ready_i = 1; prefetch_addr_i = a; prefetch_compressed_i = c;
    endtask

    task automatic do_reset();
        rst = 1; adv(); rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        adv(); adv();
        rst = 0;

        // Reset state
        cyc();
        check("rst_payload", instr_o.req_payload, 32'h0);
        check("rst_rdata", instr_o.rdata, 32'h0);
        check("rst_level", 32'(level_o), 32'd0);
        adv();

        // Aligned 32-bit with zero-latency bypass
        acc_req(32'h100); cyc(); adv();
        resp(32'h00A00093, 1'b0, MPU_OK); fetch(32'h100, 1'b0); cyc();
        check("a32_level1", 32'(level_o), 32'd1);
        check("a32_rdata", instr_o.rdata, 32'h00A00093);
        check("a32_payload", instr_o.req_payload, 32'h100);
        adv();
        cyc(); check("a32_level0", 32'(level_o), 32'd0); adv();

        // Two compressed instructions sharing one word
        acc_req(32'h100); cyc(); adv();
        resp(32'h45014581, 1'b0, MPU_OK); cyc(); adv();
        fetch(32'h100, 1'b1); cyc(); check("c_lo_rdata", instr_o.rdata, 32'h00004581); adv();
        fetch(32'h102, 1'b1); cyc();
        check("c_hi_level", 32'(level_o), 32'd1);
        check("c_hi_rdata", instr_o.rdata, 32'h00004501);
        adv();
        cyc(); check("c_level0", 32'(level_o), 32'd0); adv();

        // Misaligned 32-bit spanning two words, second word faulted
        acc_req(32'h100); cyc(); adv();
        acc_req(32'h104); resp(32'h12340000, 1'b0, MPU_OK); cyc(); adv();
        resp(32'h0000ABCD, 1'b0, MPU_RE_FAULT); fetch(32'h102, 1'b0); cyc();
        check("mis_rdata", instr_o.rdata, 32'hABCD1234);
        check("mis_mpu", 32'(instr_o.mpu_status), 32'(MPU_RE_FAULT));
        adv();
        fetch(32'h106, 1'b1); cyc(); adv();

        // Fill every entry, then push once more without a pop
        acc_req(32'h1000); cyc(); adv();
        for (int i = 1; i < DEPTH; i++) begin
            acc_req(32'h1000 + 32'(4 * i)); resp(32'hF0000000 + 32'(i - 1), 1'b0, MPU_OK); cyc(); adv();
        end
        resp(32'hF0000000 + 32'(DEPTH - 1), 1'b1, MPU_OK); cyc(); adv();
        cyc();
        check("full_level", 32'(level_o), 32'(DEPTH));
        check("full_rdata", instr_o.rdata, 32'hF0000000);
        adv();
        acc_req(32'h2000); cyc(); check("full_ovf_pre", 32'(overflow_o), 32'd0); adv();
        cyc();
        check("full_ovf", 32'(overflow_o), 32'd1);
        check("full_level_kept", 32'(level_o), 32'(DEPTH));
        adv();
        do_reset();

        // Kill with two in flight and wptr_resp at 6: rptr wraps to index 0
        for (int i = 0; i < 6; i++) begin
            acc_req(32'h3000 + 32'(4 * i)); cyc(); adv();
            resp(32'h11110000 + 32'(i), 1'b0, MPU_OK); fetch(32'h3000 + 32'(4 * i), 1'b0); cyc(); adv();
        end
        acc_req(32'h200); cyc(); adv();
        acc_req(32'h204); cyc(); adv();
        kill_if_i = 1; cyc(); check("kill_pre_level", 32'(level_o), 32'd2); adv();
        cyc();
        check("kill_level", 32'(level_o), 32'd0);
        check("kill_rptr", 32'(dut.u_ptrs.rptr_o), 32'h8);
        check("kill_outst", 32'(outstanding_o), 32'd2);
        adv();
        resp(32'hDEAD0001, 1'b0, MPU_OK); cyc(); adv();
        resp(32'hDEAD0002, 1'b0, MPU_OK); cyc(); adv();
        cyc();
        check("kill_drop_level", 32'(level_o), 32'd0);
        check("kill_drop_outst", 32'(outstanding_o), 32'd0);
        adv();
        acc_req(32'h300); cyc(); adv();
        resp(32'hCAFEF00D, 1'b0, MPU_OK); fetch(32'h300, 1'b0); cyc();
        check("post_kill_rdata", instr_o.rdata, 32'hCAFEF00D);
        check("post_kill_payload", instr_o.req_payload, 32'h300);
        adv();
        acc_req(32'h400); kill_if_i = 1; cyc(); adv();
        cyc();
        check("kill_acc_level", 32'(level_o), 32'd1);
        check("kill_acc_payload", instr_o.req_payload, 32'h400);
        adv();
        resp(32'h00000013, 1'b0, MPU_OK); fetch(32'h400, 1'b0); cyc(); adv();

        // Too many in flight: sticky overflow, then reset mid-stream
        acc_req(32'h500); cyc(); adv();
        acc_req(32'h504); cyc(); adv();
        acc_req(32'h508); cyc(); check("ovf_pre", 32'(overflow_o), 32'd0); adv();
        cyc();
        check("ovf_set", 32'(overflow_o), 32'd1);
        check("ovf_outst", 32'(outstanding_o), 32'd2);
        adv();
        for (int i = 0; i < 3; i++) begin
            cyc(); check("ovf_hold", 32'(overflow_o), 32'd1); adv();
        end
        rst = 1; acc_req(32'h600); resp(32'h12345678, 1'b1, MPU_RE_FAULT); cyc(); adv();
        rst = 0;
        cyc();
        check("mrst_level", 32'(level_o), 32'd0);
        check("mrst_outst", 32'(outstanding_o), 32'd0);
        check("mrst_ovf", 32'(overflow_o), 32'd0);
        check("mrst_payload", instr_o.req_payload, 32'h0);
        check("mrst_rdata", instr_o.rdata, 32'h0);
        adv();

        // Underflow: stray response, then pop from an empty FIFO
        resp(32'hBAD0BAD0, 1'b0, MPU_OK); cyc(); adv();
        cyc(); check("unf_resp", 32'(underflow_o), 32'd1); check("unf_outst", 32'(outstanding_o), 32'd0); adv();
        do_reset();
        fetch(32'h0, 1'b0); cyc(); adv();
        cyc(); check("unf_pop", 32'(underflow_o), 32'd1); check("unf_level", 32'(level_o), 32'd0); adv();
        do_reset();

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 2) == 0) acc_req($urandom());
            if ((m_outst > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0))
                resp($urandom(), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 5) == 0) ? MPU_RE_FAULT : MPU_OK);
            else
                resp_rdata_i = $urandom();
            prefetch_valid_i      = ($urandom_range(0, 1) == 1);
            prefetch_ready_i      = ($urandom_range(0, 3) != 0);
            prefetch_addr_i       = {$urandom_range(0, 65535) >> 0, 14'h0, ($urandom_range(0, 1) == 1), 1'b0};
            prefetch_compressed_i = ($urandom_range(0, 1) == 1);
            kill_if_i             = ($urandom_range(0, 24) == 0);
            rst                   = (n % 300 == 299);
            cyc();
            adv();
            rst = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
